// File: rtl/descriptor_server_pkg.sv
// Shared widths, pad word and FSM encoding for the descriptor server.
package descriptor_server_pkg;
   localparam int RCD_W  = 403;
   localparam int DESC_W = 384;
   localparam int ADDR_W = 11;
   localparam int GRP_W  = 9;
   localparam int LANES  = 4;

   // Pad word: row/col zero, descriptor all ones (never matches as a close distance).
   localparam logic [RCD_W-1:0] PAD_RCD = {{(RCD_W-DESC_W){1'b0}}, {DESC_W{1'b1}}};

   typedef enum logic [2:0] {IDLE, READY, FETCH, CAPTURE, PRESENT, RELEASE} state_t;

   // ceil(k/4), truncated to the group counter width.
   function automatic logic [GRP_W-1:0] calc_ngroups(input logic [ADDR_W-1:0] k);
      logic [ADDR_W:0] s;
      s = {1'b0, k} + (ADDR_W+1)'(3);
      return GRP_W'(s >> 2);
   endfunction
endpackage

// File: rtl/descriptor_server.sv
// Serves groups of four image descriptors to the matcher on a request/valid handshake.
// Optional LANE_MASK_EN adds a lane_valid output flagging lanes holding real memory data.
module descriptor_server
   import descriptor_server_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] kpt_num,
   input  logic              descriptor_request,
   output logic              descriptor_valid,
   output logic [RCD_W-1:0]  image_R_C_D_0,
   output logic [RCD_W-1:0]  image_R_C_D_1,
   output logic [RCD_W-1:0]  image_R_C_D_2,
   output logic [RCD_W-1:0]  image_R_C_D_3,
   output logic              img_mem_en,
   output logic [ADDR_W-1:0] img_mem_addr,
   input  logic [RCD_W-1:0]  img_mem_dout,
   output logic [GRP_W-1:0]  groups_served,
   output logic              busy,
   output logic              err_overrun
`ifdef LANE_MASK_EN
   ,output logic [LANES-1:0] lane_valid
`endif
);
   state_t                        state_q, state_d;
   logic [1:0]                    lane_cnt;
   logic [GRP_W-1:0]              grp_q;
   logic [ADDR_W-1:0]             kpt_q;
   logic                          ovr_q, err_q, prev_en_q;
   logic [ADDR_W-1:0]             addr;
   logic                          lane_ok, is_ovr;
   logic [LANES-1:0][RCD_W-1:0]   lanes;

   assign addr    = ADDR_W'({grp_q, lane_cnt});
   assign lane_ok = !ovr_q && (addr < kpt_q);
   assign is_ovr  = (grp_q >= calc_ngroups(kpt_q));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) state_d = READY;
      else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            READY:   if (descriptor_request) state_d = FETCH;
            FETCH:   if (lane_cnt == 2'd3) state_d = CAPTURE;
            CAPTURE: state_d = PRESENT;
            PRESENT: state_d = descriptor_request ? RELEASE : READY;
            RELEASE: if (!descriptor_request) state_d = READY;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      descriptor_valid = (state_q == PRESENT);
      busy             = (state_q != IDLE) && (state_q != READY);
      img_mem_en       = (state_q == FETCH) && lane_ok;
      img_mem_addr     = (state_q == FETCH) ? addr : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_cnt  <= '0;
         grp_q     <= '0;
         kpt_q     <= '0;
         ovr_q     <= 1'b0;
         err_q     <= 1'b0;
         prev_en_q <= 1'b0;
      end else begin
         prev_en_q <= img_mem_en;
         lane_cnt  <= (state_q == FETCH) ? lane_cnt + 2'd1 : 2'd0;
         if (start) begin
            kpt_q <= kpt_num;
            grp_q <= '0;
            ovr_q <= 1'b0;
            err_q <= 1'b0;
         end else begin
            // Overrun runs the full sequence with every lane forced to pad.
            if (state_q == READY && descriptor_request) begin
               ovr_q <= is_ovr;
               if (is_ovr) err_q <= 1'b1;
            end
            if (state_q == PRESENT && !(&grp_q)) grp_q <= grp_q + GRP_W'(1);
         end
      end
   end

   // Lane j captures the read issued one cycle earlier: lanes 0..2 in FETCH, lane 3 in CAPTURE.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic              cap_en;
      logic [RCD_W-1:0]  q;
      if (j < LANES-1) begin : g_fetch
         assign cap_en = (state_q == FETCH) && (lane_cnt == 2'(j+1));
      end else begin : g_cap
         assign cap_en = (state_q == CAPTURE);
      end
      always_ff @(posedge clk) begin
         if (!rst_n)      q <= '0;
         else if (cap_en) q <= prev_en_q ? img_mem_dout : PAD_RCD;
      end
      assign lanes[j] = q;
`ifdef LANE_MASK_EN
      logic v;
      always_ff @(posedge clk) begin
         if (!rst_n)      v <= 1'b0;
         else if (cap_en) v <= prev_en_q;
      end
      assign lane_valid[j] = v;
`endif
   end

   assign image_R_C_D_0 = lanes[0];
   assign image_R_C_D_1 = lanes[1];
   assign image_R_C_D_2 = lanes[2];
   assign image_R_C_D_3 = lanes[3];
   assign groups_served = grp_q;
   assign err_overrun   = err_q;
endmodule

// File: tb/tb_descriptor_server.sv
// Scoreboard bench for descriptor_server: directed requests push expected groups, a monitor checks them.
module tb_descriptor_server;
   import descriptor_server_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] kpt_num = '0;
   logic              descriptor_request = 1'b0;
   logic              descriptor_valid;
   logic [RCD_W-1:0]  image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3;
   logic              img_mem_en;
   logic [ADDR_W-1:0] img_mem_addr;
   logic [RCD_W-1:0]  img_mem_dout = '0;
   logic [GRP_W-1:0]  groups_served;
   logic              busy;
   logic              err_overrun;
`ifdef LANE_MASK_EN
   logic [LANES-1:0]  lane_valid;
`endif

   descriptor_server dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kpt_num(kpt_num),
      .descriptor_request(descriptor_request), .descriptor_valid(descriptor_valid),
      .image_R_C_D_0(image_R_C_D_0), .image_R_C_D_1(image_R_C_D_1),
      .image_R_C_D_2(image_R_C_D_2), .image_R_C_D_3(image_R_C_D_3),
      .img_mem_en(img_mem_en), .img_mem_addr(img_mem_addr), .img_mem_dout(img_mem_dout),
      .groups_served(groups_served), .busy(busy), .err_overrun(err_overrun)
`ifdef LANE_MASK_EN
      ,.lane_valid(lane_valid)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [RCD_W-1:0] word(input logic [ADDR_W-1:0] a);
      logic [37*ADDR_W-1:0] t;
      t = {37{a}};
      return t[RCD_W-1:0];
   endfunction

   always @(posedge clk) if (img_mem_en) img_mem_dout <= word(img_mem_addr);

   typedef struct packed {
      logic [LANES-1:0][RCD_W-1:0] l;
      logic [LANES-1:0]            m;
   } exp_t;

   int                checks = 0;
   int                failures = 0;
   int                n_valid = 0;
   exp_t              exp_q[$];
   logic [ADDR_W-1:0] addr_log[$];
   logic              prev_v = 1'b0;
   exp_t              mon_e;

   task automatic chk(input string name, input logic [RCD_W-1:0] act, input logic [RCD_W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int base, input int k);
      exp_t e;
      for (int i = 0; i < LANES; i++) begin
         if (base + i < k) begin
            e.l[i] = word(ADDR_W'(base + i));
            e.m[i] = 1'b1;
         end else begin
            e.l[i] = PAD_RCD;
            e.m[i] = 1'b0;
         end
      end
      return e;
   endfunction

   // Monitor: logs read addresses and checks every presented group against the scoreboard.
   always @(negedge clk) begin
      if (img_mem_en) addr_log.push_back(img_mem_addr);
      if (descriptor_valid) begin
         n_valid++;
         chk("valid_single_cycle", RCD_W'(prev_v), '0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got pulse expected none");
         end else begin
            mon_e = exp_q.pop_front();
            chk("lane0", image_R_C_D_0, mon_e.l[0]);
            chk("lane1", image_R_C_D_1, mon_e.l[1]);
            chk("lane2", image_R_C_D_2, mon_e.l[2]);
            chk("lane3", image_R_C_D_3, mon_e.l[3]);
`ifdef LANE_MASK_EN
            chk("lane_valid", RCD_W'(lane_valid), RCD_W'(mon_e.m));
`endif
         end
      end
      prev_v = descriptor_valid;
   end

   task automatic do_start(input int k);
      @(negedge clk);
      start = 1'b1;
      kpt_num = ADDR_W'(k);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Raises request, returns at the negedge where valid is seen (request still high).
   task automatic req();
      int lat;
      lat = -1;
      @(negedge clk);
      descriptor_request = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (descriptor_valid) begin
            lat = c;
            break;
         end
         @(posedge clk);
      end
      chk("latency", RCD_W'(lat), RCD_W'(5));
   endtask

   task automatic chk_log(input string name, input int base, input int cnt);
      chk({name, "_len"}, RCD_W'(addr_log.size()), RCD_W'(cnt));
      for (int i = 0; i < cnt && i < addr_log.size(); i++)
         chk({name, "_addr"}, RCD_W'(addr_log[i]), RCD_W'(base + i));
      addr_log.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int nv;
      repeat (3) @(negedge clk);
      chk("rst_valid", RCD_W'(descriptor_valid), '0);
      chk("rst_busy", RCD_W'(busy), '0);
      chk("rst_err", RCD_W'(err_overrun), '0);
      chk("rst_groups", RCD_W'(groups_served), '0);
      chk("rst_en", RCD_W'(img_mem_en), '0);
      chk("rst_addr", RCD_W'(img_mem_addr), '0);
      chk("rst_lane0", image_R_C_D_0, '0);
      chk("rst_lane3", image_R_C_D_3, '0);
      rst_n = 1'b1;

      // kpt=8: two full groups
      do_start(8);
      addr_log.delete();
      exp_q.push_back(mk(0, 8));
      req();
      descriptor_request = 1'b0;
      chk_log("g0", 0, 4);
      exp_q.push_back(mk(4, 8));
      req();
      descriptor_request = 1'b0;
      chk_log("g1", 4, 4);
      @(negedge clk);
      chk("groups_2", RCD_W'(groups_served), RCD_W'(2));
      chk("no_err_8", RCD_W'(err_overrun), '0);

      // request held past valid: wait in RELEASE, lanes hold
      do_start(8);
      nv = n_valid;
      exp_q.push_back(mk(0, 8));
      req();
      repeat (3) begin
         @(negedge clk);
         chk("release_busy", RCD_W'(busy), RCD_W'(1));
         chk("release_lane0", image_R_C_D_0, word(0));
      end
      descriptor_request = 1'b0;
      @(negedge clk);
      chk("ready_busy", RCD_W'(busy), '0);
      chk("one_pulse", RCD_W'(n_valid - nv), RCD_W'(1));
      repeat (3) @(negedge clk);
      chk("hold_lane3", image_R_C_D_3, word(3));
      chk("groups_1", RCD_W'(groups_served), RCD_W'(1));

      // kpt=6: partial second group
      do_start(6);
      exp_q.push_back(mk(0, 6));
      req();
      descriptor_request = 1'b0;
      addr_log.delete();
      exp_q.push_back(mk(4, 6));
      req();
      descriptor_request = 1'b0;
      chk_log("part", 4, 2);

      // kpt=4: second request overruns
      do_start(4);
      exp_q.push_back(mk(0, 4));
      req();
      descriptor_request = 1'b0;
      addr_log.delete();
      exp_q.push_back(mk(4, 4));
      req();
      descriptor_request = 1'b0;
      chk_log("ovr", 0, 0);
      chk("err_set", RCD_W'(err_overrun), RCD_W'(1));
      do_start(4);
      chk("err_clear", RCD_W'(err_overrun), '0);

      // start during FETCH lane 2 abandons the fetch
      do_start(8);
      nv = n_valid;
      @(negedge clk);
      descriptor_request = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      descriptor_request = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_no_valid", RCD_W'(n_valid - nv), '0);
      chk("abort_groups", RCD_W'(groups_served), '0);
      addr_log.delete();
      exp_q.push_back(mk(0, 8));
      req();
      descriptor_request = 1'b0;
      chk_log("restart", 0, 4);

      // reset while PRESENT
      exp_q.push_back(mk(4, 8));
      req();
      rst_n = 1'b0;
      @(negedge clk);
      chk("prst_valid", RCD_W'(descriptor_valid), '0);
      chk("prst_lane0", image_R_C_D_0, '0);
      chk("prst_lane2", image_R_C_D_2, '0);
      chk("prst_busy", RCD_W'(busy), '0);
      rst_n = 1'b1;
      nv = n_valid;
      addr_log.delete();
      repeat (10) @(negedge clk);
      chk("idle_no_valid", RCD_W'(n_valid - nv), '0);
      chk("idle_no_reads", RCD_W'(addr_log.size()), '0);
      chk("idle_busy", RCD_W'(busy), '0);
      descriptor_request = 1'b0;

      chk("scoreboard_empty", RCD_W'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
